spram_rr_arbiter: RTL



---
 rtl/spram_rr_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/spram_rr_arbiter.sv
// rtl/spram_rr_arbiter.sv - round-robin arbiter sharing one single-port RAM with burst hold
module spram_rr_arbiter #(
   parameter int NREQ      = 4,
   parameter int AW        = 3,
   parameter int DW        = 16,
   parameter int MAX_BURST = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      we,
   input  logic [NREQ*AW-1:0]   addr,
   input  logic [NREQ*DW-1:0]   wdata,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      rvalid,
   output logic [DW-1:0]        rdata,
   output logic                 ram_ce,
   output logic                 ram_we,
   output logic [AW-1:0]        ram_addr,
   output logic [DW-1:0]        ram_wdata,
   input  logic [DW-1:0]        ram_rdata
);

   localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int BW = $clog2(MAX_BURST + 1);
   localparam logic [LW-1:0] LAST_RST  = LW'(NREQ - 1);
   localparam logic [BW-1:0] BURST_SAT = BW'(MAX_BURST);

   logic [LW-1:0]   last_owner_q, last_owner_d;
   logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
   logic            prev_gnt_q, prev_gnt_d;
   logic [NREQ-1:0] rd_owner_q, rd_owner_d;
   logic            hold;
   logic            found;
   int              rot_idx;

   // Grant selection: keep the current owner while its burst allowance lasts,
   // otherwise search round-robin starting just after the last owner.
   always_comb begin
      gnt     = '0;
      found   = 1'b0;
      rot_idx = 0;
      hold    = req[last_owner_q] && prev_gnt_q &&
                (int'(burst_cnt_q) < (MAX_BURST - 1));
      if (hold) begin
         gnt[last_owner_q] = 1'b1;
      end else begin
         for (int k = 1; k <= NREQ; k++) begin
            rot_idx = (int'(last_owner_q) + k) % NREQ;
            if (!found && req[rot_idx]) begin
               gnt[rot_idx] = 1'b1;
               found        = 1'b1;
            end
         end
      end
   end

   // Next-state: owner/burst bookkeeping and the one-cycle read-return tag.
   always_comb begin
      last_owner_d = last_owner_q;
      burst_cnt_d  = '0;
      prev_gnt_d   = |gnt;
      rd_owner_d   = gnt & ~we;
      if (|gnt) begin
         for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
               last_owner_d = LW'(i);
            end
         end
         // Only a hold extends the burst; any rotate win starts a fresh one.
         if (hold) begin
            burst_cnt_d = (burst_cnt_q == BURST_SAT) ? burst_cnt_q : burst_cnt_q + 1'b1;
         end
      end
   end

   // State registers, cleared asynchronously so a pending read return is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_owner_q <= LAST_RST;
         burst_cnt_q  <= '0;
         prev_gnt_q   <= 1'b0;
         rd_owner_q   <= '0;
      end else begin
         last_owner_q <= last_owner_d;
         burst_cnt_q  <= burst_cnt_d;
         prev_gnt_q   <= prev_gnt_d;
         rd_owner_q   <= rd_owner_d;
      end
   end

   // RAM port mux: granted requester's slice, zeros when idle.
   always_comb begin
      ram_addr  = '0;
      ram_wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            ram_addr  = addr[i*AW +: AW];
            ram_wdata = wdata[i*DW +: DW];
         end
      end
      ram_ce = |gnt;
      ram_we = |(gnt & we);
   end

   assign rvalid = rd_owner_q;
   assign rdata  = (|rd_owner_q) ? ram_rdata : '0;

endmodule
